// File: rtl/sdr_pkg.sv
// Shared command encodings and beat-FSM state type for the SDRAM read-capture path.
// Command values are the raw {cs_n, ras_n, cas_n, we_n} pin pattern.
package sdr_pkg;

    localparam int CL_MIN = 1;

    typedef enum logic [3:0] {
        CMD_READ  = 4'b0101,
        CMD_BST   = 4'b0110,
        CMD_NOP   = 4'b0111,
        CMD_OTHER = 4'b1111
    } sdr_cmd_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } beat_state_e;

    function automatic sdr_cmd_e sdr_decode(input logic cs_n, input logic ras_n,
                                            input logic cas_n, input logic we_n);
        sdr_cmd_e cmd;
        case ({cs_n, ras_n, cas_n, we_n})
            4'b0101: cmd = CMD_READ;
            4'b0110: cmd = CMD_BST;
            4'b0111: cmd = CMD_NOP;
            default: cmd = CMD_OTHER;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/sdr_cl_delay.sv
// Single-bit marker shift register with a selectable tap, used to delay decoded
// commands by the CAS latency. Markers keep travelling to the end of the line.
module sdr_cl_delay #(
    parameter int DEPTH = 3,
    parameter int IDXW  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            mark_i,
    input  logic [IDXW-1:0] tap_i,
    output logic            tap_o,
    output logic            any_o
);

    logic [DEPTH-1:0] line_q;
    logic [DEPTH-1:0] line_d;

    always_comb begin
        line_d    = line_q << 1;
        line_d[0] = mark_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign tap_o = line_q[tap_i];
    assign any_o = |line_q;

endmodule

// File: rtl/sdr_rd_capture.sv
// SDRAM read-data capture: decodes READ/BST, delays them by CAS latency and
// samples dq for a burst, presenting registered beats with a burst tag.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no burst active; a start tap captures beat 0
//   ST_BURST | beats 1..BURST_LEN-1 pending; cnt_q is the next beat index
module sdr_rd_capture
    import sdr_pkg::*;
#(
    parameter int DQ_WIDTH  = 16,
    parameter int BURST_LEN = 4,
    parameter int MAX_CL    = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          cfg_sdr_cas,
    input  logic                cs_n,
    input  logic                ras_n,
    input  logic                cas_n,
    input  logic                we_n,
    input  logic [DQ_WIDTH-1:0] dq,
    output logic [DQ_WIDTH-1:0] rd_data,
    output logic                rd_valid,
    output logic                rd_last,
    output logic                rd_busy,
    output logic [3:0]          rd_id
);

    localparam int TAPW = (MAX_CL > 1) ? $clog2(MAX_CL) : 1;
    localparam int CNTW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNTW-1:0] LAST_CNT  = CNTW'(BURST_LEN - 1);
    localparam logic [CNTW-1:0] FIRST_CNT = CNTW'(1);
    localparam logic            SINGLE    = (BURST_LEN == 1);

    sdr_cmd_e        cmd;
    logic            is_read;
    logic            is_bst;
    logic [2:0]      cl_eff;
    logic [TAPW-1:0] tap_idx;
    logic            start_tap;
    logic            bst_tap;
    logic            start_any;
    logic            bst_any;

    beat_state_e         state_q;
    logic [CNTW-1:0]     cnt_q;
    logic [DQ_WIDTH-1:0] data_q;
    logic                valid_q;
    logic                last_q;
    logic [3:0]          id_q;

    assign cmd     = sdr_decode(cs_n, ras_n, cas_n, we_n);
    assign is_read = (cmd == CMD_READ);
    assign is_bst  = (cmd == CMD_BST);

    // Out-of-range latencies are clamped rather than left to index past the line.
    always_comb begin
        cl_eff = cfg_sdr_cas;
        if (cfg_sdr_cas < 3'(CL_MIN)) begin
            cl_eff = 3'(CL_MIN);
        end else if (cfg_sdr_cas > 3'(MAX_CL)) begin
            cl_eff = 3'(MAX_CL);
        end
        tap_idx = TAPW'(cl_eff - 3'd1);
    end

    sdr_cl_delay #(.DEPTH(MAX_CL), .IDXW(TAPW)) u_start_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .mark_i  (is_read),
        .tap_i   (tap_idx),
        .tap_o   (start_tap),
        .any_o   (start_any)
    );

    sdr_cl_delay #(.DEPTH(MAX_CL), .IDXW(TAPW)) u_bst_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .mark_i  (is_bst),
        .tap_i   (tap_idx),
        .tap_o   (bst_tap),
        .any_o   (bst_any)
    );

    // A start tap always wins: it both interrupts a running burst and overrides a BST.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (start_tap) begin
                data_q  <= dq;
                valid_q <= 1'b1;
                last_q  <= SINGLE;
                id_q    <= id_q + 4'd1;
                cnt_q   <= FIRST_CNT;
                state_q <= SINGLE ? ST_IDLE : ST_BURST;
            end else if (state_q == ST_BURST) begin
                if (bst_tap) begin
                    state_q <= ST_IDLE;
                end else begin
                    data_q  <= dq;
                    valid_q <= 1'b1;
                    last_q  <= (cnt_q == LAST_CNT);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + FIRST_CNT;
                    end
                end
            end
        end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;
    assign rd_last  = last_q;
    assign rd_id    = id_q;
    assign rd_busy  = start_any | bst_any | (state_q == ST_BURST);

endmodule

// File: tb/tb_sdr_rd_capture.sv
// Directed bench for sdr_rd_capture: expected beats are queued when commands are
// driven and compared every cycle against rd_valid/rd_data/rd_last.
module tb_sdr_rd_capture;

    localparam logic [3:0] C_READ = 4'b0101;
    localparam logic [3:0] C_BST  = 4'b0110;
    localparam logic [3:0] C_NOP  = 4'b0111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  cfg_sdr_cas = 3'd2;
    logic        cs_n = 1'b0;
    logic        ras_n = 1'b1;
    logic        cas_n = 1'b1;
    logic        we_n = 1'b1;
    logic [15:0] dq = 16'h0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        rd_busy;
    logic [3:0]  rd_id;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    base = 0;

    always #5 clk = ~clk;

    sdr_rd_capture dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_sdr_cas (cfg_sdr_cas),
        .cs_n        (cs_n),
        .ras_n       (ras_n),
        .cas_n       (cas_n),
        .we_n        (we_n),
        .dq          (dq),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_last     (rd_last),
        .rd_busy     (rd_busy),
        .rd_id       (rd_id)
    );

    function automatic logic [15:0] pat(input int c);
        return 16'((c * 403) ^ 42435);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s at cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic [3:0] c);
        {cs_n, ras_n, cas_n, we_n} = c;
    endtask

    task automatic check_beat();
        logic ev;
        ev = (sb.size() > 0) && (sb[0].cyc == cyc);
        chk("rd_valid", 32'(rd_valid), 32'(ev));
        if (ev) begin
            chk("rd_data", 32'(rd_data), 32'(sb[0].data));
            chk("rd_last", 32'(rd_last), 32'(sb[0].last));
            void'(sb.pop_front());
        end else begin
            chk("rd_last_idle", 32'(rd_last), 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_beat();
        set_cmd(C_NOP);
        dq = pat(cyc + 1);
    endtask

    // Advance so that the next command set lands on edge base+rel.
    task automatic goto(input int rel);
        while (cyc < base + rel - 1) tick();
    endtask

    task automatic push_burst(input int start_edge, input int n, input logic last_final);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.cyc  = start_edge + k;
            b.data = pat(start_edge + k);
            b.last = last_final && (k == n - 1);
            sb.push_back(b);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_last"},  32'(rd_last),  32'd0);
        chk({tag, "_busy"},  32'(rd_busy),  32'd0);
        chk({tag, "_id"},    32'(rd_id),    32'd0);
        chk({tag, "_data"},  32'(rd_data),  32'd0);
    endtask

    task automatic do_reset(input logic [2:0] cl);
        reset_n = 1'b0;
        cfg_sdr_cas = cl;
        sb.delete();
        #2;
        check_zero("reset");
        tick();
        tick();
        reset_n = 1'b1;
        base = cyc;
    endtask

    task automatic finish_scn(input string tag, input int id_exp);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({tag, "_rd_id"},    32'(rd_id),     32'(id_exp));
        chk({tag, "_busy_end"}, 32'(rd_busy),   32'd0);
    endtask

    initial begin
        #1;
        // CL=2 single READ
        do_reset(3'd2);
        goto(10); set_cmd(C_READ); push_burst(base + 12, 4, 1'b1);
        goto(12);
        chk("s1_busy_inflight", 32'(rd_busy), 32'd1);
        goto(25);
        finish_scn("s1", 1);

        // CL=3 back-to-back READs four cycles apart
        do_reset(3'd3);
        goto(10); set_cmd(C_READ); push_burst(base + 13, 4, 1'b1);
        goto(14); set_cmd(C_READ); push_burst(base + 17, 4, 1'b1);
        goto(30);
        finish_scn("s2", 2);

        // CL=2 read interrupt: second READ two cycles after the first
        do_reset(3'd2);
        goto(10); set_cmd(C_READ); push_burst(base + 12, 2, 1'b0);
        goto(12); set_cmd(C_READ); push_burst(base + 14, 4, 1'b1);
        goto(30);
        finish_scn("s3", 2);

        // CL=2 READ followed by BST
        do_reset(3'd2);
        goto(10); set_cmd(C_READ); push_burst(base + 12, 1, 1'b0);
        goto(11); set_cmd(C_BST);
        goto(13);
        chk("s4_busy_beat0", 32'(rd_busy), 32'd1);
        tick();
        tick();
        chk("s4_busy_c14", 32'(rd_busy), 32'd0);
        goto(25);
        finish_scn("s4", 1);

        // cfg=0 clamps to CL=1, then explicit CL=1
        do_reset(3'd0);
        goto(10); set_cmd(C_READ); push_burst(base + 11, 4, 1'b1);
        goto(20);
        cfg_sdr_cas = 3'd1;
        goto(22); set_cmd(C_READ); push_burst(base + 23, 4, 1'b1);
        goto(35);
        finish_scn("s5", 2);

        // cfg=7 clamps to CL=3
        do_reset(3'd7);
        goto(10); set_cmd(C_READ); push_burst(base + 13, 4, 1'b1);
        goto(25);
        finish_scn("s6", 1);

        // Ignored encodings: BST alone, deselected READ pattern
        do_reset(3'd2);
        goto(10); set_cmd(C_BST);
        goto(12); set_cmd(4'b1101);
        goto(20);
        finish_scn("s7", 0);

        // Reset asserted mid-burst, then a fresh READ
        do_reset(3'd2);
        goto(10); set_cmd(C_READ); push_burst(base + 12, 2, 1'b0);
        goto(14);
        reset_n = 1'b0;
        #1;
        check_zero("s8_midreset");
        tick();
        reset_n = 1'b1;
        goto(20); set_cmd(C_READ); push_burst(base + 22, 4, 1'b1);
        goto(32);
        finish_scn("s8", 1);

        // rd_id wrap: 17 gapless bursts at CL=1
        do_reset(3'd1);
        for (int i = 0; i < 17; i++) begin
            goto(10 + 4 * i); set_cmd(C_READ); push_burst(base + 11 + 4 * i, 4, 1'b1);
        end
        goto(90);
        finish_scn("s9", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
